// File: rtl/frame_store_responder.sv
// frame_store_responder: responder end of the de_ frame-store bus.
// Posts writes through a one-entry buffer (acked at once) and services reads
// against a single-port SRAM, acking them only once the read data is captured.
// The mem_* registers double as the write buffer: while they hold a write
// (mem_en=1, mem_we!=0) the buffer is full.

module frame_store_responder #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_req,
    output logic        de_ack,
    input  logic [17:0] de_addr,
    input  logic [3:0]  de_nbyte,
    input  logic        de_rnw,
    input  logic [31:0] de_w_data,
    output logic [31:0] de_r_data,
    output logic        mem_en,
    input  logic        mem_ready,
    output logic [3:0]  mem_we,
    output logic [17:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        fs_idle
);

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        ACK
    } state_t;

    state_t      state;
    logic [17:0] req_addr;
    logic [3:0]  req_we;
    logic [31:0] req_wdata;
    logic [2:0]  lat_cnt;

    logic        port_free;
    logic        read_on_port;

    // The port can take a new access next cycle if it is empty or its current occupant retires now.
    assign port_free    = !mem_en || mem_ready;
    assign read_on_port = mem_en && (mem_we == 4'b0000);

    // Outside IDLE a request is in flight; in IDLE the port can only hold a buffered write.
    assign fs_idle = (state == IDLE) && !mem_en && !de_req;

    // Request FSM, write buffer drain and read capture, all registered on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            de_ack    <= 1'b0;
            de_r_data <= 32'h0;
            mem_en    <= 1'b0;
            mem_we    <= 4'h0;
            mem_addr  <= 18'h0;
            mem_wdata <= 32'h0;
            req_addr  <= 18'h0;
            req_we    <= 4'h0;
            req_wdata <= 32'h0;
            lat_cnt   <= 3'h0;
        end else begin
            de_ack <= 1'b0;

            if (mem_en && mem_ready) begin
                mem_en <= 1'b0;
                mem_we <= 4'h0;
            end

            case (state)
                IDLE: begin
                    if (de_req && !de_ack) begin
                        req_addr  <= de_addr;
                        req_we    <= ~de_nbyte;
                        req_wdata <= de_w_data;
                        if (de_rnw) begin
                            state <= RD_ISSUE;
                            if (port_free) begin
                                mem_en   <= 1'b1;
                                mem_we   <= 4'h0;
                                mem_addr <= de_addr;
                            end
                        end else if (de_nbyte == 4'hF) begin
                            state  <= ACK;
                            de_ack <= 1'b1;
                        end else if (port_free) begin
                            mem_en    <= 1'b1;
                            mem_we    <= ~de_nbyte;
                            mem_addr  <= de_addr;
                            mem_wdata <= de_w_data;
                            state     <= ACK;
                            de_ack    <= 1'b1;
                        end else begin
                            state <= WR_WAIT;
                        end
                    end
                end

                WR_WAIT: begin
                    if (port_free) begin
                        mem_en    <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                        state     <= ACK;
                        de_ack    <= 1'b1;
                    end
                end

                RD_ISSUE: begin
                    if (read_on_port) begin
                        if (mem_ready) begin
                            state   <= RD_WAIT;
                            lat_cnt <= 3'(RD_LAT - 1);
                        end
                    end else if (port_free) begin
                        mem_en   <= 1'b1;
                        mem_we   <= 4'h0;
                        mem_addr <= req_addr;
                    end
                end

                RD_WAIT: begin
                    if (lat_cnt == 3'h0) begin
                        de_r_data <= mem_rdata;
                        de_ack    <= 1'b1;
                        state     <= ACK;
                    end else begin
                        lat_cnt <= lat_cnt - 3'h1;
                    end
                end

                ACK: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_store_responder.sv
// tb_frame_store_responder: randomized and directed bench for frame_store_responder.
// A behavioural SRAM drives mem_ready/mem_rdata; a transaction-level model predicts
// ack timing, port contents and read data, and is compared against the DUT every cycle.

module tb_frame_store_responder;

    localparam int RD_LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        de_req;
    logic        de_ack;
    logic [17:0] de_addr;
    logic [3:0]  de_nbyte;
    logic        de_rnw;
    logic [31:0] de_w_data;
    logic [31:0] de_r_data;
    logic        mem_en;
    logic        mem_ready;
    logic [3:0]  mem_we;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        fs_idle;

    frame_store_responder #(.RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .de_req    (de_req),
        .de_ack    (de_ack),
        .de_addr   (de_addr),
        .de_nbyte  (de_nbyte),
        .de_rnw    (de_rnw),
        .de_w_data (de_w_data),
        .de_r_data (de_r_data),
        .mem_en    (mem_en),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .fs_idle   (fs_idle)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] sram [int];
    logic [31:0] gold [int];
    int          wr_log [$];
    bit          ready_script [$];
    bit          rand_mode = 1'b0;
    int          cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;
    rd_t rdq [$];

    int ack_total  = 0;
    int ack_consec = 0;
    bit ack_prev   = 1'b0;

    // Model state: in-flight request, buffered write, pending read and expected read data.
    bit          m_busy;
    int          m_ack_at;
    bit          m_ack_rd;
    logic [31:0] m_rdata;
    bit          m_buf_full;
    logic [17:0] m_buf_addr;
    logic [3:0]  m_buf_we;
    logic [31:0] m_buf_data;
    bit          m_wr_wait;
    logic [17:0] m_wr_addr;
    logic [3:0]  m_wr_we;
    logic [31:0] m_wr_data;
    bit          m_rd_wait;
    bit          m_rd_port;
    logic [17:0] m_rd_addr;
    logic [31:0] m_rd_val;
    int          m_cyc;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] merge_bytes(logic [31:0] old, logic [31:0] nw, logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] sram_rd(int a);
        return sram.exists(a) ? sram[a] : 32'h0;
    endfunction

    function automatic logic [31:0] gold_rd(int a);
        return gold.exists(a) ? gold[a] : 32'h0;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_ack_at = -1; m_ack_rd = 0; m_rdata = 32'h0;
        m_buf_full = 0; m_wr_wait = 0; m_rd_wait = 0; m_rd_port = 0;
        m_cyc = 0;
    endfunction

    initial clk = 1'b0;
    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Behavioural SRAM: commits writes, schedules read data RD_LAT cycles after acceptance.
    always @(posedge clk) begin
        if (!rst_n) begin
            rdq.delete();
        end else if (mem_en && mem_ready) begin
            if (mem_we == 4'h0) begin
                rdq.push_back('{due: cyc + RD_LAT, data: sram_rd(int'(mem_addr))});
            end else begin
                sram[int'(mem_addr)] = merge_bytes(sram_rd(int'(mem_addr)), mem_wdata, mem_we);
                wr_log.push_back(int'(mem_addr));
            end
        end
        cyc++;
        #2;
        if (ready_script.size() > 0) mem_ready = ready_script.pop_front();
        else mem_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            mem_rdata = rdq[0].data;
            void'(rdq.pop_front());
        end else begin
            mem_rdata = $urandom;
        end
    end

    logic e_ack;
    logic e_en;
    logic e_idle;
    logic free;

    // Per-cycle compare against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (de_ack) begin
            ack_total++;
            if (ack_prev) ack_consec++;
        end
        ack_prev = de_ack;

        if (!rst_n) begin
            check_output("rst_de_ack", 32'(de_ack), 32'h0);
            check_output("rst_mem_en", 32'(mem_en), 32'h0);
            check_output("rst_mem_we", 32'(mem_we), 32'h0);
            check_output("rst_de_r_data", de_r_data, 32'h0);
            if (!de_req) check_output("rst_fs_idle", 32'(fs_idle), 32'h1);
            model_reset();
        end else begin
            e_ack  = (m_ack_at == m_cyc);
            e_en   = m_buf_full || m_rd_port;
            e_idle = !m_busy && !m_buf_full && !de_req;
            check_output("de_ack", 32'(de_ack), 32'(e_ack));
            check_output("mem_en", 32'(mem_en), 32'(e_en));
            check_output("fs_idle", 32'(fs_idle), 32'(e_idle));
            check_output("de_r_data", de_r_data, m_rdata);
            if (m_buf_full) begin
                check_output("wr_mem_we", 32'(mem_we), 32'(m_buf_we));
                check_output("wr_mem_addr", 32'(mem_addr), 32'(m_buf_addr));
                check_output("wr_mem_wdata", mem_wdata, m_buf_data);
            end
            if (m_rd_port) begin
                check_output("rd_mem_we", 32'(mem_we), 32'h0);
                check_output("rd_mem_addr", 32'(mem_addr), 32'(m_rd_addr));
            end

            free = !e_en || mem_ready;
            if (m_buf_full && mem_ready) begin
                gold[int'(m_buf_addr)] = merge_bytes(gold_rd(int'(m_buf_addr)), m_buf_data, m_buf_we);
                m_buf_full = 0;
            end
            if (m_rd_port && mem_ready) begin
                m_rd_port = 0;
                m_rd_val  = gold_rd(int'(m_rd_addr));
                m_ack_at  = m_cyc + RD_LAT + 1;
                m_ack_rd  = 1;
            end else if (m_rd_wait && free) begin
                m_rd_wait = 0;
                m_rd_port = 1;
            end
            if (m_wr_wait && free) begin
                m_buf_full = 1; m_buf_addr = m_wr_addr; m_buf_we = m_wr_we; m_buf_data = m_wr_data;
                m_wr_wait = 0; m_ack_at = m_cyc + 1; m_ack_rd = 0;
            end
            if (e_ack) begin
                m_busy = 0;
            end else if (!m_busy && de_req) begin
                m_busy = 1;
                if (de_rnw) begin
                    m_rd_addr = de_addr;
                    if (free) m_rd_port = 1;
                    else m_rd_wait = 1;
                end else if (de_nbyte == 4'hF) begin
                    m_ack_at = m_cyc + 1; m_ack_rd = 0;
                end else if (free) begin
                    m_buf_full = 1; m_buf_addr = de_addr; m_buf_we = ~de_nbyte; m_buf_data = de_w_data;
                    m_ack_at = m_cyc + 1; m_ack_rd = 0;
                end else begin
                    m_wr_wait = 1; m_wr_addr = de_addr; m_wr_we = ~de_nbyte; m_wr_data = de_w_data;
                end
            end
            if (m_ack_rd && m_ack_at == m_cyc + 1) m_rdata = m_rd_val;
            m_cyc++;
        end
    end

    // Issues one request (called at posedge+1) and records when its own SRAM access and its ack appear.
    task automatic apply_stimulus(input bit rnw, input logic [17:0] addr, input logic [3:0] nb,
                                  input logic [31:0] wd, input bit hold,
                                  output int en_off, output int ack_off,
                                  output logic [3:0] we_at_en, output logic [31:0] rd);
        de_req = 1'b1; de_rnw = rnw; de_addr = addr; de_nbyte = nb; de_w_data = wd;
        en_off = -1; ack_off = -1; we_at_en = 4'h0; rd = 32'h0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (en_off < 0 && k > 0 && mem_en && mem_addr == addr &&
                (rnw ? (mem_we == 4'h0) : (mem_we == 4'(~nb)))) begin
                en_off = k;
                we_at_en = mem_we;
            end
            if (de_ack) begin
                ack_off = k;
                rd = de_r_data;
                break;
            end
        end
        check_output("ack_seen", 32'(ack_off >= 0), 32'h1);
        @(posedge clk);
        #1;
        if (!hold) de_req = 1'b0;
    endtask

    int          en_off, ack_off, acks_before, consec_before;
    logic [3:0]  we_seen;
    logic [31:0] rd_seen;

    // Directed scenarios pinning the model, then a randomized run.
    initial begin
        rst_n = 1'b0; de_req = 1'b0; de_rnw = 1'b0; de_addr = '0; de_nbyte = 4'hF; de_w_data = '0;
        mem_ready = 1'b1; mem_rdata = 32'h0;
        model_reset();
        sram[32'h10] = 32'hDEADBEEF;    gold[32'h10] = 32'hDEADBEEF;
        sram[32'h3FFFF] = 32'hAABBCCDD; gold[32'h3FFFF] = 32'hAABBCCDD;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_de_ack", 32'(de_ack), 32'h0);
        check_output("reset_de_r_data", de_r_data, 32'h0);
        check_output("reset_mem_en", 32'(mem_en), 32'h0);
        check_output("reset_mem_we", 32'(mem_we), 32'h0);
        check_output("reset_mem_addr", 32'(mem_addr), 32'h0);
        check_output("reset_mem_wdata", mem_wdata, 32'h0);
        check_output("reset_fs_idle", 32'(fs_idle), 32'h1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic read");
        apply_stimulus(1'b1, 18'h00010, 4'h0, 32'h0, 1'b0, en_off, ack_off, we_seen, rd_seen);
        check_output("rd_en_cycle", 32'(en_off), 32'd1);
        check_output("rd_ack_cycle", 32'(ack_off), 32'd4);
        check_output("rd_data", rd_seen, 32'hDEADBEEF);

        $display("[TB] byte-masked write, readback, no-op write");
        apply_stimulus(1'b0, 18'h3FFFF, 4'b1010, 32'h11223344, 1'b0, en_off, ack_off, we_seen, rd_seen);
        check_output("wr_ack_cycle", 32'(ack_off), 32'd1);
        check_output("wr_en_cycle", 32'(en_off), 32'd1);
        check_output("wr_we", 32'(we_seen), 32'h5);
        apply_stimulus(1'b1, 18'h3FFFF, 4'h0, 32'h0, 1'b0, en_off, ack_off, we_seen, rd_seen);
        check_output("merge_ack_cycle", 32'(ack_off), 32'd4);
        check_output("merge_data", rd_seen, 32'hAA22CC44);
        apply_stimulus(1'b0, 18'h00020, 4'hF, 32'h12345678, 1'b0, en_off, ack_off, we_seen, rd_seen);
        check_output("noop_ack_cycle", 32'(ack_off), 32'd1);
        check_output("noop_no_en", 32'(en_off), 32'hFFFFFFFF);

        $display("[TB] stalled write then read of same address");
        ready_script = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        apply_stimulus(1'b0, 18'h00123, 4'h0, 32'hCAFEF00D, 1'b1, en_off, ack_off, we_seen, rd_seen);
        check_output("stall_wr_ack", 32'(ack_off), 32'd1);
        apply_stimulus(1'b1, 18'h00123, 4'h0, 32'h0, 1'b0, en_off, ack_off, we_seen, rd_seen);
        check_output("stall_rd_en", 32'(en_off), 32'd5);
        check_output("stall_rd_ack", 32'(ack_off), 32'd8);
        check_output("stall_rd_data", rd_seen, 32'hCAFEF00D);

        $display("[TB] back-to-back writes, first stalled");
        wr_log.delete();
        ready_script = '{1'b1, 1'b0, 1'b0, 1'b0};
        apply_stimulus(1'b0, 18'h00201, 4'h0, 32'h01010101, 1'b1, en_off, ack_off, we_seen, rd_seen);
        check_output("b2b_w1_ack", 32'(ack_off), 32'd1);
        apply_stimulus(1'b0, 18'h00202, 4'h0, 32'h02020202, 1'b0, en_off, ack_off, we_seen, rd_seen);
        check_output("b2b_w2_ack", 32'(ack_off), 32'd3);
        check_output("b2b_w2_en", 32'(en_off), 32'd3);
        check_output("b2b_write_count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            check_output("b2b_first_addr", 32'(wr_log[0]), 32'h201);
            check_output("b2b_second_addr", 32'(wr_log[1]), 32'h202);
        end

        $display("[TB] reset during read wait");
        de_req = 1'b1; de_rnw = 1'b1; de_addr = 18'h00010; de_nbyte = 4'h0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0; de_req = 1'b0;
        #1;
        check_output("rstrd_mem_en", 32'(mem_en), 32'h0);
        check_output("rstrd_de_ack", 32'(de_ack), 32'h0);
        check_output("rstrd_fs_idle", 32'(fs_idle), 32'h1);
        acks_before = ack_total;
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_output("rstrd_no_ack", 32'(ack_total), 32'(acks_before));

        $display("[TB] reset with buffer full");
        wr_log.delete();
        ready_script = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        apply_stimulus(1'b0, 18'h00300, 4'h0, 32'h0BADCAFE, 1'b0, en_off, ack_off, we_seen, rd_seen);
        check_output("rstwr_buf_full", 32'(mem_en), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_output("rstwr_mem_en", 32'(mem_en), 32'h0);
        check_output("rstwr_fs_idle", 32'(fs_idle), 32'h1);
        ready_script.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("rstwr_no_sram_write", 32'(wr_log.size()), 32'h0);
        apply_stimulus(1'b1, 18'h00300, 4'h0, 32'h0, 1'b0, en_off, ack_off, we_seen, rd_seen);
        check_output("post_rst_rd_en", 32'(en_off), 32'd1);
        check_output("post_rst_rd_ack", 32'(ack_off), 32'd4);
        check_output("post_rst_rd_data", rd_seen, 32'h0);

        $display("[TB] continuous request over four mixed transfers");
        acks_before = ack_total;
        consec_before = ack_consec;
        apply_stimulus(1'b0, 18'h00210, 4'h0, 32'hA5A5A5A5, 1'b1, en_off, ack_off, we_seen, rd_seen);
        apply_stimulus(1'b1, 18'h00210, 4'h0, 32'h0, 1'b1, en_off, ack_off, we_seen, rd_seen);
        apply_stimulus(1'b0, 18'h00211, 4'hF, 32'hFFFFFFFF, 1'b1, en_off, ack_off, we_seen, rd_seen);
        apply_stimulus(1'b1, 18'h00010, 4'h0, 32'h0, 1'b0, en_off, ack_off, we_seen, rd_seen);
        check_output("cont_ack_count", 32'(ack_total - acks_before), 32'd4);
        check_output("cont_no_consec", 32'(ack_consec - consec_before), 32'd0);
        check_output("cont_last_rd", rd_seen, 32'hDEADBEEF);

        $display("[TB] randomized traffic");
        rand_mode = 1'b1;
        for (int i = 0; i < 250; i++) begin
            logic [17:0] a;
            logic [3:0]  nb;
            bit          hold;
            case ($urandom_range(0, 3))
                0:       a = 18'h00010;
                1:       a = 18'h3FFFF;
                default: a = 18'(18'h00100 + $urandom_range(0, 7));
            endcase
            nb   = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
            hold = ($urandom_range(0, 1) == 1);
            apply_stimulus($urandom_range(0, 1) == 1, a, nb, $urandom, hold,
                           en_off, ack_off, we_seen, rd_seen);
            if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        de_req = 1'b0;
        rand_mode = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_output("final_fs_idle", 32'(fs_idle), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/frame_store_responder.md
# frame_store_responder

Responder end of the `de_` frame-store bus. It accepts read and write requests from the edge detector, or any other `de_` initiator, and services them against a single-port word-addressed SRAM. Writes are posted through a one-entry write buffer and acknowledged immediately. Reads are acknowledged only when the data is available. It sits between the detector's `de_` port and the frame-store memory macro.

## Interface
Parameters:
- `RD_LAT`, default 2: SRAM read latency in cycles, counted from the cycle in which `mem_en && mem_ready` is sampled to the cycle in which `mem_rdata` is valid. Legal range 1–7.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `de_req` in 1: request pending. It is held high; the initiator changes the request fields only after `de_ack`.
- `de_ack` out 1: one-cycle pulse. The current request is complete; for reads, `de_r_data` is valid.
- `de_addr` in 18: word address.
- `de_nbyte` in 4: active-low byte-lane enables for writes. Bit i=0 writes byte i. Ignored for reads.
- `de_rnw` in 1: 1 = read, 0 = write.
- `de_w_data` in 32: write data.
- `de_r_data` out 32: read data. Holds its value until the next read completes.
- `mem_en` out 1: SRAM access request.
- `mem_ready` in 1: SRAM accepts the access this cycle. When low, all `mem_*` outputs are held stable.
- `mem_we` out 4: per-byte write enable. All zero means a read.
- `mem_addr` out 18: SRAM word address.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: SRAM read data.
- `fs_idle` out 1: high when no request is in flight and the write buffer is empty.

## Operation
- Reset values (async, immediate): `de_ack`=0, `de_r_data`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `fs_idle`=1. FSM is in IDLE and the write buffer is empty.
- A reset asserted mid-operation drops `mem_en` at once. A buffered write or an outstanding read is discarded, with no ack.
- FSM states: IDLE, WR_WAIT, RD_ISSUE, RD_WAIT, ACK.
- IDLE: the request is sampled when `de_req`=1 and `de_ack`=0. Requiring `de_ack`=0 means the ack cycle never re-accepts the same request. All request fields are captured.
  - A write goes to ACK if the buffer is empty, or is draining this cycle; otherwise it goes to WR_WAIT.
  - A read goes to RD_ISSUE.
- WR_WAIT: when the buffer empties, the captured write is loaded into the buffer → ACK.
- Write into the buffer: loaded as `mem_we` = ~`de_nbyte`.
  - `de_nbyte`=4'hF is a legal no-op: it is acked, and the buffer is not loaded.
- Buffer drain:
  - While the buffer is full, drive `mem_en`=1 with the buffered addr/we/data.
  - The entry retires in the cycle `mem_ready`=1.
  - The buffer drains independently of the FSM state.
- RD_ISSUE: waits until the buffer is empty; buffered writes always complete before any later read. It then drives `mem_en`=1, `mem_we`=0 and `mem_addr`, holding them until `mem_ready`=1 → RD_WAIT.
- RD_WAIT: a latency counter runs for `RD_LAT` cycles. `mem_rdata` is registered into `de_r_data` → ACK.
- ACK: `de_ack`=1 for exactly one cycle → IDLE.
- Only one request is in flight at a time. The memory port never carries a read and a buffered write in the same cycle.
- `fs_idle` = (state==IDLE) && buffer empty && !`de_req`.

## Timing
Cycle 0 is the cycle in which the request is sampled.
- Write, buffer empty: `de_ack` is high in cycle 1. `mem_en` is high from cycle 1. With `mem_ready`=1 the write retires in cycle 1.
- Write arriving while the previous write is still stalled by `mem_ready`=0: the ack is delayed until 1 cycle after the buffer retires.
- Back-to-back writes with `mem_ready`=1 throughout: one write every 2 cycles (sample, ack).
- Read, buffer empty, `mem_ready`=1:
  - `mem_en` is high in cycle 1.
  - `mem_rdata` is valid in cycle 1+`RD_LAT`.
  - `de_ack` is high and `de_r_data` is valid in cycle 2+`RD_LAT`. For `RD_LAT`=2 that is cycle 4.
- Each cycle of `mem_ready`=0, and each cycle spent draining a prior write, adds exactly one cycle of read latency.
- `de_r_data` updates only in the cycle `de_ack` rises for a read. It is unchanged by writes.

## Test plan
- Reset → all outputs at reset values. Then read addr 0x00010 with SRAM preloaded 0xDEADBEEF and `RD_LAT`=2 → `mem_en` in cycle 1, `de_ack` in cycle 4, `de_r_data`=0xDEADBEEF.
- Write 0x3FFFF, data 0x11223344, `de_nbyte`=4'b1010 → `de_ack` in cycle 1, `mem_we`=4'b0101, then a readback returns 0xXX22XX44 merged with the old bytes. Write with `de_nbyte`=4'hF → ack in cycle 1, no `mem_en`.
- Hold `mem_ready`=0 for 5 cycles during a write followed by a read of the same address → the read's `mem_en` is issued only after the write retires, and the read returns the new data.
- Two back-to-back writes with the first stalled by `mem_ready`=0 for 3 cycles → the second ack is delayed until 1 cycle after the first retires, and exactly two SRAM writes occur, in order.
- Assert `rst_n`=0 while in RD_WAIT and while the buffer is full → `mem_en` drops immediately, no `de_ack`, `fs_idle`=1. A subsequent read completes normally.
- `de_req` held high continuously over 4 mixed requests → exactly 4 `de_ack` pulses, none on consecutive cycles.
